wb_bram_responder: RTL and testbench
====================================

// Module: wb_bram_responder
// PURPOSE
//  Wishbone classic single-beat responder backed by on-chip block RAM; the memory end of the
//  cyc/stb/we/ack bus that the DRAM self-test initiator drives. Stand-in for the DDR3 wrapper
//  in simulation and bring-up: identical port set and word size, programmable access latency,
//  `initialized` raised only after a power-on clear sweep.
// PARAMETERS
//  WORD_SIZE   256   data width of data_i/data_o, bits
//  ADDR_WIDTH  25    word-index width carried in addr_i[ADDR_LSB +: ADDR_WIDTH]
//  ADDR_LSB    7     byte-address bits below the word index (addr_i = {index, 7'h0})
//  MEM_DEPTH   1024  words implemented (power of two, <= 2**ADDR_WIDTH)
//  LATENCY     4     cycles from request accept to ack_o/err_o (>= 1)
// PORTS
//  sys_clk_100mhz  in   1          clock
//  rst_n           in   1          reset, asynchronous, active-low
//  initialized     out  1          1 = clear sweep done, requests serviced
//  cyc_i           in   1          bus cycle valid
//  stb_i           in   1          strobe
//  we_i            in   1          1 = write, 0 = read
//  addr_i          in   32         byte address
//  data_i          in   WORD_SIZE  write data
//  data_o          out  WORD_SIZE  read data, valid while ack_o=1
//  ack_o           out  1          one-cycle completion pulse
//  err_o           out  1          one-cycle error pulse (out-of-range index)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=S_CLEAR, clr_idx=0, initialized=0, ack_o=0, err_o=0,
//    data_o=0, lat_cnt=0. Reset mid-transaction aborts it; a pending write is never committed.
//  - S_CLEAR: writes 0 to mem[clr_idx] each cycle, clr_idx++; after writing MEM_DEPTH-1 ->
//    S_IDLE and initialized<=1 (MEM_DEPTH cycles after reset release). cyc/stb ignored.
//  - S_IDLE: on cyc_i&stb_i latch we_i, data_i, idx=addr_i[ADDR_LSB+:ADDR_WIDTH];
//    lat_cnt<=LATENCY-1; -> S_WAIT. addr_i[ADDR_LSB-1:0] ignored.
//  - S_WAIT: if !cyc_i -> S_IDLE (abort, no write, no ack). Else if lat_cnt==0 -> S_RESP,
//    else lat_cnt--.
//  - S_RESP (one cycle): idx >= MEM_DEPTH -> err_o=1, ack_o=0, no memory access, data_o=0.
//    Otherwise ack_o=1; write: mem[idx]<=latched data, data_o unchanged; read: data_o=mem[idx]
//    (RAM read issued in last S_WAIT cycle so data is registered at S_RESP). -> S_IDLE.
//  - Latency: request sampled at edge N -> ack_o high during cycle N+LATENCY+1.
//  - Initiator drops stb the edge it sees ack; responder does not re-sample until S_IDLE, so
//    a held stb after ack starts a new transaction (back-to-back permitted, 1 idle cycle min).
//  - Changes on we_i/addr_i/data_i after accept are ignored (values latched at accept).
//  - Read-after-write same index returns the new value (write completes before next accept).
//  - ack_o and err_o never both 1; both 0 outside S_RESP.
//  - Memory inferred as single-port block RAM, one access per cycle, no byte enables.
// STRUCTURE
//  - Package wb_bram_pkg: typedef enum logic [1:0] {S_CLEAR,S_IDLE,S_WAIT,S_RESP} resp_state_t;
//    localparam IDX_W = $clog2(MEM_DEPTH).
//  - Sub-module wb_bram_sp_ram (single-port RAM, sync read, WORD_SIZE x MEM_DEPTH); FSM and
//    latency counter in top level.
// TESTING
//  1. Reset release -> initialized=0 for 1024 cycles, then 1; read idx 5 -> ack, data_o=0.
//  2. Write {32{8'hA5}} to addr 32'h0 then read 32'h0 -> ack after 5 cycles each, data_o=A5...A5.
//  3. Write 256'h55BB..8899 to addr {25'd1023,7'h0}, read back -> equal; read idx 1022 -> 0.
//  4. Read addr {25'd1024,7'h0} -> err_o=1 one cycle, ack_o=0; prior contents unchanged.
//  5. Write {32{8'hFF}} idx 7, drop cyc_i 2 cycles after accept -> no ack; read idx 7 -> 0.
//  6. Assert rst_n=0 during S_WAIT of write to idx 3 -> outputs reset, clear sweep reruns,
//     read idx 3 after initialized -> 0.

Source files
------------

// File: rtl/wb_bram_pkg.sv
// Shared types for the block-RAM Wishbone responder.
// Holds the responder FSM state encoding and default sizing.
package wb_bram_pkg;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_WAIT,
    S_RESP
  } resp_state_t;

  localparam int MEM_DEPTH_DEF = 1024;
  localparam int IDX_W = $clog2(MEM_DEPTH_DEF);

endpackage

// File: rtl/wb_bram_sp_ram.sv
// Single-port block RAM, synchronous read, no byte enables.
// Ports: clk, rst_n (clears read register), en, we, addr, wdata, rdata.
module wb_bram_sp_ram #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register only moves on a read, so it holds across writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (en && !we) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/wb_bram_responder.sv
// Wishbone classic single-beat responder backed by block RAM.
// Ports: sys_clk_100mhz, rst_n, initialized, cyc_i/stb_i/we_i/addr_i/data_i in,
// data_o/ack_o/err_o out. Clears memory after reset, then serves requests.
module wb_bram_responder
  import wb_bram_pkg::*;
#(
  parameter int WORD_SIZE  = 256,
  parameter int ADDR_WIDTH = 25,
  parameter int ADDR_LSB   = 7,
  parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
  parameter int LATENCY    = 4
) (
  input  logic                 sys_clk_100mhz,
  input  logic                 rst_n,
  output logic                 initialized,
  input  logic                 cyc_i,
  input  logic                 stb_i,
  input  logic                 we_i,
  input  logic [31:0]          addr_i,
  input  logic [WORD_SIZE-1:0] data_i,
  output logic [WORD_SIZE-1:0] data_o,
  output logic                 ack_o,
  output logic                 err_o
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int LW = $clog2(LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_IDX =
    ADDR_WIDTH'(MEM_DEPTH);

  resp_state_t state_q, state_d;
  logic [AW-1:0]         clr_q, clr_d;
  logic                  init_q, init_d;
  logic [LW-1:0]         lat_q, lat_d;
  logic                  we_q, we_d;
  logic [WORD_SIZE-1:0]  wdat_q, wdat_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;

  logic                  ram_en;
  logic                  ram_we;
  logic [AW-1:0]         ram_addr;
  logic [WORD_SIZE-1:0]  ram_wdata;
  logic [WORD_SIZE-1:0]  ram_rdata;
  logic                  in_range;

  logic unused_lsb;
  assign unused_lsb = ^addr_i[ADDR_LSB-1:0];

  assign in_range = idx_q < DEPTH_IDX;

  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    init_d    = init_q;
    lat_d     = lat_q;
    we_d      = we_q;
    wdat_d    = wdat_q;
    idx_d     = idx_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = idx_q[AW-1:0];
    ram_wdata = wdat_q;
    unique case (state_q)
      S_CLEAR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = clr_q;
        ram_wdata = '0;
        clr_d     = clr_q + AW'(1);
        if (clr_q == AW'(MEM_DEPTH - 1)) begin
          state_d = S_IDLE;
          init_d  = 1'b1;
        end
      end
      S_IDLE: begin
        if (cyc_i && stb_i) begin
          we_d    = we_i;
          wdat_d  = data_i;
          idx_d   = addr_i[ADDR_LSB +: ADDR_WIDTH];
          lat_d   = LW'(LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!cyc_i) begin
          state_d = S_IDLE;
        end else if (lat_q == '0) begin
          // Issue the read now so the registered data
          // lines up with the ack cycle.
          ram_en  = in_range && !we_q;
          ack_d   = in_range;
          err_d   = !in_range;
          state_d = S_RESP;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      S_RESP: begin
        ram_en  = in_range && we_q;
        ram_we  = we_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      clr_q   <= '0;
      init_q  <= 1'b0;
      lat_q   <= '0;
      we_q    <= 1'b0;
      wdat_q  <= '0;
      idx_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      init_q  <= init_d;
      lat_q   <= lat_d;
      we_q    <= we_d;
      wdat_q  <= wdat_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  wb_bram_sp_ram #(
    .WIDTH (WORD_SIZE),
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (sys_clk_100mhz),
    .rst_n (rst_n),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign initialized = init_q;
  assign ack_o       = ack_q;
  assign err_o       = err_q;
  assign data_o      = err_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_wb_bram_responder.sv
// Directed bench for wb_bram_responder.
// Table of single-beat transfers plus abort and mid-flight reset sequences.
module tb_wb_bram_responder;

  localparam int W   = 256;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cyc = 1'b0;
  logic         stb = 1'b0;
  logic         we = 1'b0;
  logic [31:0]  addr = '0;
  logic [W-1:0] wdat = '0;
  logic         initialized;
  logic         ack;
  logic         err;
  logic [W-1:0] rdat;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wb_bram_responder #(
    .WORD_SIZE  (W),
    .ADDR_WIDTH (25),
    .ADDR_LSB   (7),
    .MEM_DEPTH  (1024),
    .LATENCY    (LAT)
  ) dut (
    .sys_clk_100mhz (clk),
    .rst_n          (rst_n),
    .initialized    (initialized),
    .cyc_i          (cyc),
    .stb_i          (stb),
    .we_i           (we),
    .addr_i         (addr),
    .data_i         (wdat),
    .data_o         (rdat),
    .ack_o          (ack),
    .err_o          (err)
  );

  typedef struct {
    logic         w;
    logic [31:0]  a;
    logic [W-1:0] d;
    logic         xa;
    logic         xe;
    logic         cd;
    logic [W-1:0] xq;
  } vec_t;

  localparam logic [W-1:0] PAT =
    256'h55BBCCDD_EEFF0011_22334455_66778899_AABBCCDD_EEFF0011_22334455_66778899;

  task automatic chk(input string name,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ix(input int i);
    return {i[24:0], 7'h0};
  endfunction

  task automatic xfer(input logic w, input logic [31:0] a,
                      input logic [W-1:0] d, output int lat,
                      output logic ak, output logic er,
                      output logic [W-1:0] q, output logic tail);
    lat = 0; ak = 0; er = 0; q = '0; tail = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; addr = a; wdat = d;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) begin
        we = ~w; addr = ~a; wdat = ~d;
      end
      if (ack || err) begin
        lat = k; ak = ack; er = err; q = rdat;
        break;
      end
    end
    cyc = 0; stb = 0; we = 0;
    @(negedge clk);
    tail = !ack && !err;
  endtask

  task automatic wait_init(output int n, output logic seen);
    n = 0; seen = 0;
    while (!initialized && n < 2000) begin
      @(negedge clk);
      n++;
      if (ack || err) seen = 1;
    end
  endtask

  vec_t v[13];
  int lat;
  int n;
  logic ak, er, tail, seen;
  logic [W-1:0] q;

  initial begin
    v[0]  = '{0, ix(5),    '0,         1, 0, 1, '0};
    v[1]  = '{1, 32'h0,    {32{8'hA5}}, 1, 0, 0, '0};
    v[2]  = '{0, 32'h0,    '0,         1, 0, 1, {32{8'hA5}}};
    v[3]  = '{1, ix(1023), PAT,        1, 0, 0, '0};
    v[4]  = '{0, ix(1023), '0,         1, 0, 1, PAT};
    v[5]  = '{0, ix(1022), '0,         1, 0, 1, '0};
    v[6]  = '{0, ix(1024), '0,         0, 1, 1, '0};
    v[7]  = '{0, 32'h0,    '0,         1, 0, 1, {32{8'hA5}}};
    v[8]  = '{0, 32'h7F,   '0,         1, 0, 1, {32{8'hA5}}};
    v[9]  = '{1, ix(1025), {32{8'h3C}}, 0, 1, 1, '0};
    v[10] = '{0, ix(1),    '0,         1, 0, 1, '0};
    v[11] = '{1, ix(9),    ~PAT,       1, 0, 0, '0};
    v[12] = '{0, ix(9),    '0,         1, 0, 1, ~PAT};

    repeat (3) @(negedge clk);
    chk("rst_init", W'(initialized), W'(0));
    chk("rst_ack", W'(ack), W'(0));
    chk("rst_err", W'(err), W'(0));
    chk("rst_data", rdat, '0);

    // Request held during the sweep must be ignored.
    cyc = 1; stb = 1; we = 1; addr = ix(5); wdat = '1;
    rst_n = 1;
    wait_init(n, seen);
    cyc = 0; stb = 0; we = 0;
    chk("init_cycles", W'(n), W'(1024));
    chk("sweep_no_ack", W'(seen), W'(0));
    repeat (4) begin
      @(negedge clk);
      if (ack || err) seen = 1;
    end
    chk("post_sweep_idle", W'(seen), W'(0));

    for (int i = 0; i < 13; i++) begin
      xfer(v[i].w, v[i].a, v[i].d, lat, ak, er, q, tail);
      chk($sformatf("v%0d_ack", i), W'(ak), W'(v[i].xa));
      chk($sformatf("v%0d_err", i), W'(er), W'(v[i].xe));
      chk($sformatf("v%0d_lat", i), W'(lat), W'(LAT + 1));
      chk($sformatf("v%0d_pulse", i), W'(tail), W'(1));
      if (v[i].cd) chk($sformatf("v%0d_data", i), q, v[i].xq);
    end

    // Abort: drop cyc two cycles after accept.
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; addr = ix(7); wdat = {32{8'hFF}};
    @(negedge clk);
    @(negedge clk);
    cyc = 0; stb = 0; we = 0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack || err) seen = 1;
    end
    chk("abort_no_ack", W'(seen), W'(0));
    xfer(0, ix(7), '0, lat, ak, er, q, tail);
    chk("abort_rd_ack", W'(ak), W'(1));
    chk("abort_rd_data", q, '0);

    // Reset during the wait phase of a write.
    xfer(0, 32'h0, '0, lat, ak, er, q, tail);
    chk("pre_rst_data", rdat, {32{8'hA5}});
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; addr = ix(3); wdat = PAT;
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("mid_rst_init", W'(initialized), W'(0));
    chk("mid_rst_ack", W'(ack), W'(0));
    chk("mid_rst_err", W'(err), W'(0));
    chk("mid_rst_data", rdat, '0);
    cyc = 0; stb = 0; we = 0;
    @(negedge clk);
    rst_n = 1;
    wait_init(n, seen);
    chk("reinit_cycles", W'(n), W'(1024));
    xfer(0, ix(3), '0, lat, ak, er, q, tail);
    chk("rst_idx3_ack", W'(ak), W'(1));
    chk("rst_idx3_data", q, '0);
    xfer(0, 32'h0, '0, lat, ak, er, q, tail);
    chk("rst_idx0_data", q, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
